// File: rtl/gpio_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one GPIO register block among NUM_REQ requesters.
// Each granted access runs ACCESS -> SETTLE -> RESP, one cycle each, with all outputs registered.
module gpio_access_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           rdata,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        busy,
  output logic                        gpio_we,
  output logic [DATA_W-1:0]           gpio_wdata,
  input  logic [DATA_W-1:0]           gpio_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    SETTLE,
    RESP
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic                lat_we;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   cap_rdata;

  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    always_comb wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // First set request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr;
    cand      = ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      cap_rdata  <= '0;
      ack        <= '0;
      rdata      <= '0;
      grant_idx  <= '0;
      busy       <= 1'b0;
      gpio_we    <= 1'b0;
      gpio_wdata <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant_idx <= sel_idx;
            lat_we    <= req_we[sel_idx];
            lat_wdata <= wdata_arr[sel_idx];
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          gpio_we <= lat_we;
          if (lat_we) gpio_wdata <= lat_wdata;
          state <= SETTLE;
        end
        SETTLE: begin
          // GPIO output is registered by the block during this cycle; capture it here.
          gpio_we   <= 1'b0;
          cap_rdata <= gpio_rdata;
          state     <= RESP;
        end
        RESP: begin
          ack <= NUM_REQ'(1) << grant_idx;
          if (!lat_we) rdata <= cap_rdata;
          ptr   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Bench for gpio_access_arbiter: directed scenarios plus randomized requesters,
// all outputs compared every cycle against a transaction-timeline reference model.
module tb_gpio_access_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*W-1:0]  req_wdata = '0;
  logic [N-1:0]    ack;
  logic [W-1:0]    rdata;
  logic [1:0]      grant_idx;
  logic            busy;
  logic            gpio_we;
  logic [W-1:0]    gpio_wdata;
  logic [W-1:0]    gpio_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  gpio_access_arbiter #(.NUM_REQ(N), .DATA_W(W), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .grant_idx(grant_idx), .busy(busy),
    .gpio_we(gpio_we), .gpio_wdata(gpio_wdata), .gpio_rdata(gpio_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) if (a[i]) return i;
    return -1;
  endfunction

  // Reference model: a granted transaction is a timeline measured in edges
  // since the grant (write strobe at +1, read capture at +2, ack at +3).
  int            m_age = -1;
  int            m_ptr = 0;
  int            m_grant = 0;
  bit            m_we = 1'b0;
  logic [W-1:0]  m_wd = '0;
  logic [W-1:0]  m_cap = '0;
  logic [N-1:0]  e_ack = '0;
  logic [W-1:0]  e_rdata = '0;
  logic [W-1:0]  e_gwdata = '0;
  int            e_gidx = 0;
  bit            e_busy = 1'b0;
  bit            e_gwe = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_age = -1; m_ptr = 0; m_grant = 0; m_we = 0; m_wd = '0; m_cap = '0;
      e_ack = '0; e_rdata = '0; e_gwdata = '0; e_gidx = 0; e_busy = 0; e_gwe = 0;
    end else begin
      e_ack = '0;
      if (m_age < 0) begin
        for (int k = 0; k < N && m_age < 0; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (req[j]) begin
            m_grant = j;
            m_we    = req_we[j];
            m_wd    = req_wdata[j*W +: W];
            m_age   = 0;
            e_gidx  = j;
            e_busy  = 1;
          end
        end
      end else begin
        m_age++;
        if (m_age == 1) begin
          e_gwe = m_we;
          if (m_we) e_gwdata = m_wd;
        end else if (m_age == 2) begin
          e_gwe = 0;
          m_cap = gpio_rdata;
        end else begin
          e_ack[m_grant] = 1'b1;
          if (!m_we) e_rdata = m_cap;
          m_ptr  = (m_grant + 1) % N;
          e_busy = 0;
          m_age  = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", 64'(ack), 64'(e_ack));
      check("rdata", 64'(rdata), 64'(e_rdata));
      check("grant_idx", 64'(grant_idx), 64'(e_gidx));
      check("busy", 64'(busy), 64'(e_busy));
      check("gpio_we", 64'(gpio_we), 64'(e_gwe));
      check("gpio_wdata", 64'(gpio_wdata), 64'(e_gwdata));
      check("ack_onehot", 64'($countones(ack) <= 1), 64'(1));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  // Raise one request, hold until its ack (bounded), then drop it.
  task automatic run_txn(input int idx, input bit we, input logic [W-1:0] wd,
                         output int lat, output int wep, output logic [W-1:0] wd_seen,
                         output logic [N-1:0] ack_seen, output logic [W-1:0] rd_seen);
    req[idx] = 1'b1;
    req_we[idx] = we;
    req_wdata[idx*W +: W] = wd;
    lat = 0; wep = 0; wd_seen = '0; ack_seen = '0; rd_seen = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (gpio_we) begin
        wep++;
        wd_seen = gpio_wdata;
      end
      if (ack != '0) begin
        lat = c;
        ack_seen = ack;
        rd_seen = rdata;
        break;
      end
    end
    req[idx] = 1'b0;
  endtask

  initial begin
    int lat, wep, cnt, last;
    logic [W-1:0] wds, rds;
    logic [N-1:0] acks;
    int order[$];
    int times[$];
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    bit pend[N];

    do_reset();

    // Write from requester 2
    run_txn(2, 1'b1, 32'hDEADBEEF, lat, wep, wds, acks, rds);
    check("wr_latency", 64'(lat), 64'(4));
    check("wr_ack", 64'(acks), 64'(4'b0100));
    check("wr_we_pulses", 64'(wep), 64'(1));
    check("wr_wdata", 64'(wds), 64'(32'hDEADBEEF));
    check("wr_grant", 64'(grant_idx), 64'(2));

    // Read from requester 1
    gpio_rdata = 32'h12345678;
    run_txn(1, 1'b0, 32'hA5A5A5A5, lat, wep, wds, acks, rds);
    check("rd_ack", 64'(acks), 64'(4'b0010));
    check("rd_data", 64'(rds), 64'(32'h12345678));
    check("rd_we_pulses", 64'(wep), 64'(0));

    // Round-robin with all requesters held high from reset
    do_reset();
    req_we = '0;
    req = '1;
    for (int c = 1; c <= 40 && order.size() < 5; c++) begin
      @(negedge clk);
      gpio_rdata = $urandom;
      if (ack != '0) begin
        order.push_back(idx_of(ack));
        times.push_back(c);
      end
    end
    req = '0;
    check("rr_count", 64'(order.size()), 64'(5));
    for (int i = 0; i < order.size() && i < 5; i++) begin
      check("rr_order", 64'(order[i]), 64'(exp_rr[i]));
      if (i > 0) check("rr_spacing", 64'(times[i] - times[i-1]), 64'(4));
    end

    // Pointer wrap: serve 2 (ptr -> 3), then 0 and 3 compete
    run_txn(2, 1'b0, '0, lat, wep, wds, acks, rds);
    check("wrap_pre", 64'(acks), 64'(4'b0100));
    order.delete();
    req_we = '0;
    req = 4'b1001;
    for (int c = 1; c <= 20 && order.size() < 2; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        order.push_back(idx_of(ack));
        req = req & ~ack;
      end
    end
    req = '0;
    check("wrap_count", 64'(order.size()), 64'(2));
    if (order.size() == 2) begin
      check("wrap_first", 64'(order[0]), 64'(3));
      check("wrap_second", 64'(order[1]), 64'(0));
    end

    // Reset in ACCESS of a write, with ptr left at 3 beforehand
    run_txn(2, 1'b1, 32'h0BADF00D, lat, wep, wds, acks, rds);
    req[1] = 1'b1; req_we[1] = 1'b1; req_wdata[1*W +: W] = 32'hCAFEF00D;
    @(negedge clk);
    check("abort_in_access", 64'(busy), 64'(1));
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    check("abort_we", 64'(gpio_we), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_grant", 64'(grant_idx), 64'(0));
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack != '0) cnt++;
    end
    check("abort_no_ack", 64'(cnt), 64'(0));
    req_we = '0;
    req = 4'b1010;
    last = -1;
    for (int c = 1; c <= 12 && last < 0; c++) begin
      @(negedge clk);
      if (ack != '0) last = idx_of(ack);
    end
    req = '0;
    check("abort_ptr_reset", 64'(last), 64'(1));
    repeat (6) @(negedge clk);

    // Request withdrawn during SETTLE
    req_we[1] = 1'b0;
    req[1] = 1'b1;
    repeat (2) @(negedge clk);
    req[1] = 1'b0;
    acks = '0;
    for (int c = 1; c <= 6 && acks == '0; c++) begin
      @(negedge clk);
      acks = ack;
    end
    check("withdraw_ack", 64'(acks), 64'(4'b0010));
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack != '0) cnt++;
    end
    check("withdraw_no_regrant", 64'(cnt), 64'(0));

    // Randomized requesters, occasional withdrawals and resets
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gpio_rdata = $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        if (pend[i] && (ack[i] || $urandom_range(0, 63) == 0)) begin
          pend[i] = 0;
          req[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          req[i] = 1'b1;
          req_we[i] = 1'($urandom);
          req_wdata[i*W +: W] = $urandom;
        end
      end
    end
    rst_n = 1'b1;
    req = '0;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gpio_access_arbiter.md
Name: gpio_access_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit GPIO register block among NUM_REQ requesters (e.g. CPU bus, debug port, DMA).
- Accepts one read or write request at a time, drives the GPIO block's write_enable/data pins for a fixed-length transaction, captures read data, and returns a one-cycle ack to the granted requester.
- Sits between the requester interconnect and the GPIO block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, GPIO data width.
- IDX_W, 2, width of grant index; must be at least ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  NUM_REQ  per-requester request; held high until ack.
- req_we  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
- req_wdata  input  NUM_REQ*DATA_W  flattened write data; requester i uses bits [i*DATA_W +: DATA_W].
- ack  output  NUM_REQ  one-hot, one-cycle completion pulse.
- rdata  output  DATA_W  read data, valid while ack is high for a read.
- grant_idx  output  IDX_W  index of the current or last granted requester.
- busy  output  1  high whenever the FSM is not in IDLE.
- gpio_we  output  1  to GPIO block write_enable.
- gpio_wdata  output  DATA_W  to GPIO block data input.
- gpio_rdata  input  DATA_W  from GPIO block gpio_out.

Behaviour:
- Reset (rst_n low at a rising edge):
  - FSM goes to IDLE.
  - ack, rdata, grant_idx, busy, gpio_we and gpio_wdata all go to 0.
  - Priority pointer goes to 0, so requester 0 has highest priority first.
  - Reset overrides any in-flight transaction: no ack is issued for it, and gpio_we drops to 0 on the same edge.
- FSM states are IDLE, ACCESS, SETTLE, RESP. Every non-IDLE state lasts exactly 1 cycle.
- IDLE:
  - If any req bit is high, select the first set bit searching upward from ptr, wrapping modulo NUM_REQ.
  - Latch the selected index into grant_idx, and latch that requester's req_we and wdata.
  - Go to ACCESS. If no req bit is high, stay in IDLE.
- ACCESS:
  - gpio_we = latched we.
  - gpio_wdata = latched wdata on a write; holds its previous value on a read.
  - Go to SETTLE.
- SETTLE:
  - gpio_we = 0. This gives the GPIO block one cycle to register gpio_out.
  - Go to RESP.
- RESP:
  - ack[grant_idx] = 1.
  - On a read, rdata = gpio_rdata sampled at the SETTLE->RESP edge. On a write, rdata holds its previous value.
  - ptr = grant_idx + 1, wrapping to 0 after NUM_REQ-1.
  - Go to IDLE.
- Latency and throughput:
  - req sampled high in IDLE at edge E0 gives ack high in the cycle after edge E3.
  - Minimum spacing between accepted transactions is 4 cycles.
- ack is 0 outside RESP. At most one ack bit is high at any time.
- busy = 1 in ACCESS, SETTLE and RESP.
- gpio_we is 0 in every state except ACCESS during a write.
- Requester rules:
  - Must hold req, req_we and wdata stable until ack. Only the values latched in IDLE are used.
  - If req drops mid-transaction, the transaction still completes and ack still pulses.
  - If req is still high in the IDLE cycle after ack, it counts as a new request and competes under round-robin.
- Requests arriving while busy wait; they are arbitrated at the next IDLE cycle.
- Simultaneous requests are resolved by round-robin only; each requester waits at most NUM_REQ-1 transactions.
- The pointer advances only on completion (RESP), never on an aborted transaction.

Test Plan:
- Write with NUM_REQ=4 after reset: req[2]=1, we=1, wdata=0xDEADBEEF → gpio_we=1 for exactly one cycle with gpio_wdata=0xDEADBEEF. ack=4'b0100 for one cycle, 3 cycles after the sampling edge. grant_idx=2.
- Read: GPIO model returns 0x12345678 → req[1] read gives ack=4'b0010 with rdata=0x12345678. gpio_we stays 0 throughout.
- Round-robin: all four req high from reset, reads held until each ack → ack order 0,1,2,3,0. Acks 4 cycles apart. No requester is skipped.
- Pointer wrap: ptr=3 after serving requester 2, then req[0] and req[3] high → requester 3 is granted first, then requester 0.
- Reset mid-operation: assert rst_n=0 while in ACCESS of a write → no ack. gpio_we, busy and grant_idx are 0 on the next edge. The next request is arbitrated starting from index 0.
- Request withdrawn: req[1] drops during SETTLE → ack[1] still pulses in RESP. The FSM returns to IDLE and no re-grant of requester 1 occurs.
